// File: rtl/rc_pred_pkg.sv
// Shared constants for the rc_pred parity-predicted adder.
package rc_pred_pkg;

  localparam int unsigned RC_WIDTH = 3;

endpackage

// File: rtl/rc_full_adder.sv
// Single-bit full adder cell used to build the primary ripple-carry chain.
module rc_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/rc_pred.sv
// Ripple-carry adder with parity prediction and a duplicate carry chain for
// concurrent error detection. All results are registered on clk_50.
module rc_pred
  import rc_pred_pkg::*;
#(
  parameter int unsigned WIDTH = RC_WIDTH
) (
  input  logic             clk_50,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             parin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             parout,
  output logic             error_out
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_n;
  logic [WIDTH:0]   cd;
  logic [WIDTH-1:0] gd;
  logic [WIDTH-1:0] pd;
  logic             pred;
  logic             err_n;

  assign c[0] = cin;

  // Primary chain: one full adder per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rc_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_n[i]),
      .co (c[i+1])
    );
  end

  // Duplicate carry chain from its own generate/propagate terms
  always_comb begin
    gd    = a & b;
    pd    = a ^ b;
    cd    = '0;
    cd[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cd[i+1] = gd[i] | (pd[i] & cd[i]);
    end
  end

  // Predicted sum parity and mismatch detection against the actual sum
  always_comb begin
    pred = ~parin ^ cin;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      pred = pred ^ cd[i];
    end
    err_n = (pred ^ (^s_n)) | (c[WIDTH:1] != cd[WIDTH:1]);
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      s         <= '0;
      cout      <= 1'b0;
      parout    <= 1'b0;
      error_out <= 1'b0;
    end else begin
      s         <= s_n;
      cout      <= c[WIDTH];
      parout    <= pred;
      error_out <= err_n;
    end
  end

endmodule

// File: tb/tb_rc_pred.sv
// Self-checking bench for rc_pred: directed cases, exhaustive sweep,
// randomized operations with bad parity and asynchronous resets.
module tb_rc_pred;

  localparam int unsigned W = 3;

  logic         clk_50;
  logic         reset_l;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         parin;
  logic [W-1:0] s;
  logic         cout;
  logic         parout;
  logic         error_out;

  int unsigned n_checks;
  int unsigned n_errors;

  rc_pred #(.WIDTH(W)) dut (
    .clk_50    (clk_50),
    .reset_l   (reset_l),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .parin     (parin),
    .s         (s),
    .cout      (cout),
    .parout    (parout),
    .error_out (error_out)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Correct odd parity over {a,b}
  function automatic logic good_par(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < W; i++) ones += x[i] + y[i];
    return (ones % 2 == 0);
  endfunction

  // Apply one operation, then compare against arithmetic reference after the edge
  task automatic do_op(input int unsigned va, input int unsigned vb, input int unsigned vc,
                       input bit bad_par, input string tag);
    int unsigned sum;
    int unsigned ones;
    logic        exp_par;
    @(negedge clk_50);
    a     = va[W-1:0];
    b     = vb[W-1:0];
    cin   = vc[0];
    parin = good_par(va[W-1:0], vb[W-1:0]) ^ bad_par;
    sum   = va + vb + vc;
    ones  = 0;
    for (int unsigned i = 0; i < W; i++) ones += (sum >> i) & 1;
    // A wrong input parity flips the prediction away from the true sum parity
    exp_par = ((ones % 2) == 1) ^ bad_par;
    @(posedge clk_50);
    #1;
    check({tag, ".s"},     32'(s),         sum % (1 << W));
    check({tag, ".cout"},  32'(cout),      (sum >> W) & 1);
    check({tag, ".par"},   32'(parout),    32'(exp_par));
    check({tag, ".err"},   32'(error_out), 32'(bad_par));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".s"},    32'(s),         0);
    check({tag, ".cout"}, 32'(cout),      0);
    check({tag, ".par"},  32'(parout),    0);
    check({tag, ".err"},  32'(error_out), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_l  = 1'b0;
    a        = 3'd7;
    b        = 3'd7;
    cin      = 1'b1;
    parin    = good_par(3'd7, 3'd7);

    // Reset held across edges
    repeat (3) @(posedge clk_50);
    #1;
    check_zero("rst_hold");

    @(negedge clk_50);
    reset_l = 1'b1;
    @(posedge clk_50);
    #1;
    check("rst_rel.s",    32'(s),         7);
    check("rst_rel.cout", 32'(cout),      1);
    check("rst_rel.par",  32'(parout),    1);
    check("rst_rel.err",  32'(error_out), 0);

    // Directed cases
    do_op(3, 5, 0, 1'b0, "d_3p5");
    do_op(1, 0, 0, 1'b1, "d_badpar");
    do_op(1, 0, 0, 1'b0, "d_recover");
    do_op(7, 7, 1, 1'b0, "d_wrap");
    do_op(0, 0, 0, 1'b0, "d_zero");

    // Exhaustive sweep with an asynchronous reset in the middle
    for (int unsigned k = 0; k < 128; k++) begin
      if (k == 60) begin
        @(negedge clk_50);
        #2;
        reset_l = 1'b0;
        #1;
        check_zero("sweep_arst");
        #1;
        reset_l = 1'b1;
      end
      do_op((k >> 4) & 7, (k >> 1) & 7, k & 1, 1'b0, "sweep");
    end

    // Randomized operations, occasional bad parity and async reset
    for (int unsigned k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk_50);
        #($urandom_range(1, 3));
        reset_l = 1'b0;
        #1;
        check_zero("rnd_arst");
        @(negedge clk_50);
        reset_l = 1'b1;
      end
      do_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
